// File: rtl/systolic_seq_ctrl.sv
// systolic_seq_ctrl: sequences clear, feed, flush and drain phases of the systolic tile array.
// Each edge presents the next sequence step; under STALL it is shown with all strobes off and not committed.
module systolic_seq_ctrl #(
  parameter int UNITS_X = 2,
  parameter int UNITS_Y = 2,
  parameter int M_X     = 3,
  parameter int ADDR_W  = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic              STALL,
  output logic              BUSY,
  output logic              DONE,
  output logic              RD_EN,
  output logic [ADDR_W-1:0] RD_ADDR,
  output logic              C1,
  output logic              C2,
  output logic [1:0]        C3,
  output logic              WR_EN,
  output logic [ADDR_W-1:0] WR_ADDR
);
  localparam int K    = M_X + 1;
  localparam int FL   = UNITS_X + UNITS_Y - 1;
  localparam int MAXP = (K > FL) ? ((K > UNITS_Y) ? K : UNITS_Y) : ((FL > UNITS_Y) ? FL : UNITS_Y);
  localparam int CW   = $clog2(MAXP + 1);

  if (K > 2**ADDR_W || UNITS_Y > 2**ADDR_W) begin : g_chk
    $error("systolic_seq_ctrl: ADDR_W too small for K or UNITS_Y");
  end

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FEED, S_FLUSH, S_DRAIN, S_FIN} st_t;

  st_t               st_q, st_d, nst;
  logic [CW-1:0]     cnt_q, cnt_d, ncnt, term;
  logic              phase, last, stl;
  logic              c2p_q, c2p_d;
  logic              busy_q, busy_d, done_q, done_d, rd_en_q, rd_en_d;
  logic              c1_q, c1_d, c2_q, c2_d, wr_en_q, wr_en_d;
  logic [1:0]        c3_q, c3_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;

  always_comb begin
    term  = st_q == S_FEED ? CW'(K - 1) : st_q == S_FLUSH ? CW'(FL - 1) : CW'(UNITS_Y - 1);
    phase = st_q == S_FEED || st_q == S_FLUSH || st_q == S_DRAIN;
    last  = cnt_q == term;
    nst   = st_q == S_IDLE  ? (START ? S_CLEAR : S_IDLE) :
            st_q == S_CLEAR ? S_FEED :
            st_q == S_FIN   ? S_IDLE :
            last            ? st_t'(st_q + 3'd1) : st_q;
    ncnt  = (phase && !last) ? cnt_q + CW'(1) : '0;
    stl   = STALL && st_q != S_IDLE;
    st_d  = stl ? st_q : nst;
    cnt_d = stl ? cnt_q : ncnt;
    // c2p remembers a read whose MAC has not been issued yet; a stall defers it
    c2p_d     = stl ? c2p_q : nst == S_FEED;
    c2_d      = !stl && c2p_q;
    rd_en_d   = !stl && nst == S_FEED;
    c1_d      = !stl && nst == S_CLEAR;
    wr_en_d   = !stl && nst == S_DRAIN;
    done_d    = !stl && nst == S_FIN;
    busy_d    = stl || nst != S_IDLE;
    c3_d      = stl ? 2'b00 : (nst == S_FEED || nst == S_FLUSH) ? 2'b01 : nst == S_DRAIN ? 2'b10 : 2'b00;
    rd_addr_d = nst == S_FEED ? ADDR_W'(ncnt) :
                (nst == S_IDLE || nst == S_CLEAR) ? '0 : ADDR_W'(K - 1);
    wr_addr_d = nst == S_DRAIN ? ADDR_W'(ncnt) : nst == S_FIN ? ADDR_W'(UNITS_Y - 1) : '0;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      st_q      <= S_IDLE;
      cnt_q     <= '0;
      c2p_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      c1_q      <= 1'b0;
      c2_q      <= 1'b0;
      c3_q      <= 2'b00;
      wr_en_q   <= 1'b0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
    end else begin
      st_q      <= st_d;
      cnt_q     <= cnt_d;
      c2p_q     <= c2p_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rd_en_q   <= rd_en_d;
      c1_q      <= c1_d;
      c2_q      <= c2_d;
      c3_q      <= c3_d;
      wr_en_q   <= wr_en_d;
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
    end
  end

  assign BUSY    = busy_q;
  assign DONE    = done_q;
  assign RD_EN   = rd_en_q;
  assign RD_ADDR = rd_addr_q;
  assign C1      = c1_q;
  assign C2      = c2_q;
  assign C3      = c3_q;
  assign WR_EN   = wr_en_q;
  assign WR_ADDR = wr_addr_q;
endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// tb_systolic_seq_ctrl: directed checks of the sequencer with default and enlarged array parameters.
module tb_systolic_seq_ctrl;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, stall = 1'b0, start_p = 1'b0, stall_p = 1'b0;
  logic busy, done, rd_en, c1, c2, wr_en;
  logic [1:0] c3;
  logic [3:0] rd_addr, wr_addr;
  logic p_busy, p_done, p_rd_en, p_c1, p_c2, p_wr_en;
  logic [1:0] p_c3;
  logic [3:0] p_rd_addr, p_wr_addr;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  systolic_seq_ctrl dut (
    .CLK(clk), .RST(rst), .START(start), .STALL(stall), .BUSY(busy), .DONE(done),
    .RD_EN(rd_en), .RD_ADDR(rd_addr), .C1(c1), .C2(c2), .C3(c3), .WR_EN(wr_en), .WR_ADDR(wr_addr)
  );

  systolic_seq_ctrl #(.UNITS_X(3), .UNITS_Y(4), .M_X(5), .ADDR_W(4)) dut_p (
    .CLK(clk), .RST(rst), .START(start_p), .STALL(stall_p), .BUSY(p_busy), .DONE(p_done),
    .RD_EN(p_rd_en), .RD_ADDR(p_rd_addr), .C1(p_c1), .C2(p_c2), .C3(p_c3), .WR_EN(p_wr_en),
    .WR_ADDR(p_wr_addr)
  );

  task automatic chk(input string tag, input logic [31:0] got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] ctl();
    return {busy, done, rd_en, c1, c2, c3, wr_en};
  endfunction

  task automatic pass_chk(input string nm, input int n, input logic [7:0] ce[16], input int ae[16],
                          input int we[16], input logic [15:0] stm, input logic [15:0] stl);
    start = 1'b1;
    stall = 1'b0;
    for (int i = 1; i <= n; i++) begin
      step();
      chk($sformatf("%s c%0d ctl", nm, i), ctl(), ce[i]);
      if (ae[i] >= 0) chk($sformatf("%s c%0d rd_addr", nm, i), rd_addr, ae[i]);
      if (we[i] >= 0) chk($sformatf("%s c%0d wr_addr", nm, i), wr_addr, we[i]);
      start = stm[i];
      stall = stl[i];
    end
  endtask

  logic [7:0] ce_nom[16] = '{8'h00, 8'h90, 8'hA2, 8'hAA, 8'hAA, 8'hAA, 8'h8A, 8'h82, 8'h82,
                             8'h85, 8'h85, 8'hC0, 8'h00, 8'h00, 8'h00, 8'h00};
  int ae_nom[16] = '{-1, -1, 0, 1, 2, 3, 3, 3, 3, -1, -1, -1, -1, -1, -1, -1};
  int we_nom[16] = '{-1, -1, -1, -1, -1, -1, -1, -1, -1, 0, 1, -1, -1, -1, -1, -1};
  logic [7:0] ce_stl[16] = '{8'h00, 8'h90, 8'hA2, 8'hAA, 8'h80, 8'h80, 8'h80, 8'hAA, 8'hAA,
                             8'h8A, 8'h82, 8'h82, 8'h85, 8'h85, 8'hC0, 8'h00};
  int ae_stl[16] = '{-1, -1, 0, 1, 2, 2, 2, 2, 3, 3, 3, 3, -1, -1, -1, -1};
  int we_stl[16] = '{-1, -1, -1, -1, -1, -1, -1, -1, -1, -1, -1, -1, 0, 1, -1, -1};
  logic [7:0] ce_b2b[16] = '{8'h00, 8'h90, 8'hA2, 8'hAA, 8'hAA, 8'hAA, 8'h8A, 8'h82, 8'h82,
                             8'h85, 8'h85, 8'hC0, 8'h00, 8'h90, 8'hA2, 8'h00};
  int ae_b2b[16] = '{-1, -1, 0, 1, 2, 3, 3, 3, 3, -1, -1, -1, -1, -1, 0, -1};

  initial begin
    int nrd, nc2, n01, nwr, done_at, c1_at;
    repeat (2) step();
    rst = 1'b0;
    step();
    chk("rst_idle ctl", ctl(), 0);
    chk("rst_idle rd_addr", rd_addr, 0);
    chk("rst_idle wr_addr", wr_addr, 0);
    step();
    chk("rst_idle2 ctl", ctl(), 0);
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    #2 rst = 1'b1;
    #1 chk("rst_async ctl", ctl(), 0);
    chk("rst_async rd_addr", rd_addr, 0);
    step();
    rst = 1'b0;
    step();
    chk("rst_rel ctl", ctl(), 0);

    pass_chk("nom", 12, ce_nom, ae_nom, we_nom, 16'h0000, 16'h0000);
    pass_chk("stall", 15, ce_stl, ae_stl, we_stl, 16'h0000, 16'h0038);
    pass_chk("ign", 13, ce_nom, ae_nom, we_nom, 16'h0808, 16'h0000);
    pass_chk("b2b", 14, ce_b2b, ae_b2b, we_nom, 16'hFFFF, 16'h0000);
    start = 1'b0;
    #2 rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    chk("b2b_rst ctl", ctl(), 0);

    pass_chk("drain_rst", 9, ce_nom, ae_nom, we_nom, 16'h0000, 16'h0000);
    #2 rst = 1'b1;
    #1 chk("drain_rst wr_en", wr_en, 0);
    chk("drain_rst ctl", ctl(), 0);
    step();
    rst = 1'b0;
    step();
    chk("drain_rst idle ctl", ctl(), 0);
    chk("drain_rst idle wr_addr", wr_addr, 0);
    pass_chk("clean", 12, ce_nom, ae_nom, we_nom, 16'h0000, 16'h0000);

    nrd = 0; nc2 = 0; n01 = 0; nwr = 0; done_at = 0; c1_at = 0;
    start_p = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      step();
      start_p = 1'b0;
      if (p_c1 && c1_at == 0) c1_at = c;
      if (p_rd_en) begin
        chk($sformatf("p rd_addr c%0d", c), p_rd_addr, nrd);
        nrd++;
      end
      if (p_c2) nc2++;
      if (p_c3 == 2'b01) n01++;
      if (p_wr_en) begin
        chk($sformatf("p wr_addr c%0d", c), p_wr_addr, nwr);
        nwr++;
      end
      if (p_done && done_at == 0) done_at = c;
    end
    chk("p c1_at", c1_at, 1);
    chk("p done_at", done_at, 18);
    chk("p rd_cnt", nrd, 6);
    chk("p c2_cnt", nc2, 6);
    chk("p c3_mac_cnt", n01, 12);
    chk("p wr_cnt", nwr, 4);
    chk("p busy_end", p_busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
